// File: rtl/wb_excp_ctrl.sv
// Write-back stage exception/ERTN controller: commits one latched instruction,
// classifies exceptions, drives CSR writes and redirects, then holds the pipe for FLUSH_GAP cycles.
module wb_excp_ctrl #(
  parameter int unsigned FLUSH_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [4:0]  ms_excp,
  input  logic        ms_ertn,
  input  logic        ms_csr_we,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wdata,
  input  logic        has_int,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        csr_wr_en,
  output logic [13:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [31:0] era_in,
  output logic [5:0]  ecode_in,
  output logic [8:0]  esubcode_in,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush_all,
  output logic [31:0] excp_count
);

  localparam logic [3:0] GAP_INIT   = 4'(FLUSH_GAP);
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_r;
  logic [3:0]  gap_cnt_r;
  logic        ws_valid_r;
  logic [31:0] pc_r;
  logic [4:0]  excp_r;
  logic        ertn_r;
  logic        csr_we_r;
  logic [13:0] csr_num_r;
  logic [31:0] csr_wdata_r;
  logic [31:0] excp_count_r;

  logic        commit_s;
  logic        excp_hit_s;
  logic        ertn_hit_s;
  logic        normal_s;

  // Priority INT > ADEF > ALE > SYS > BRK > INE; flag bit0 is adef.
  function automatic logic [5:0] excp_ecode(input logic int_hit, input logic [4:0] flags);
    logic [5:0] code;
    if (int_hit)       code = ECODE_INT;
    else if (flags[0]) code = ECODE_ADEF;
    else if (flags[1]) code = ECODE_ALE;
    else if (flags[2]) code = ECODE_SYS;
    else if (flags[3]) code = ECODE_BRK;
    else if (flags[4]) code = ECODE_INE;
    else               code = 6'h00;
    return code;
  endfunction

  assign ws_allowin = (state_r == RUN);
  assign excp_count = excp_count_r;

  // Commit classification: exceptions (incl. interrupts) override ERTN.
  always_comb begin
    commit_s   = ws_valid_r && (state_r == RUN);
    excp_hit_s = commit_s && (has_int || (excp_r != 5'b00000));
    ertn_hit_s = commit_s && !excp_hit_s && ertn_r;
    normal_s   = commit_s && !excp_hit_s && !ertn_hit_s;
  end

  // Commit outputs, all zero outside a commit cycle.
  always_comb begin
    csr_wr_en      = 1'b0;
    wr_addr        = 14'h0000;
    wr_data        = 32'h0000_0000;
    excp_flush     = 1'b0;
    ertn_flush     = 1'b0;
    era_in         = 32'h0000_0000;
    ecode_in       = 6'h00;
    esubcode_in    = 9'h000;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    if (excp_hit_s) begin
      excp_flush     = 1'b1;
      era_in         = pc_r;
      ecode_in       = excp_ecode(has_int, excp_r);
      redirect_valid = 1'b1;
      redirect_pc    = csr_eentry;
    end else if (ertn_hit_s) begin
      ertn_flush     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = csr_era;
    end else if (normal_s) begin
      csr_wr_en = csr_we_r;
      wr_addr   = csr_num_r;
      wr_data   = csr_wdata_r;
    end else begin
      csr_wr_en = 1'b0;
    end
    flush_all = excp_hit_s || ertn_hit_s || (state_r == HOLD);
  end

  // Write-back pipeline register: valid only for the cycle after a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_r  <= 1'b0;
      pc_r        <= 32'h0000_0000;
      excp_r      <= 5'b00000;
      ertn_r      <= 1'b0;
      csr_we_r    <= 1'b0;
      csr_num_r   <= 14'h0000;
      csr_wdata_r <= 32'h0000_0000;
    end else if (ms_to_ws_valid && ws_allowin) begin
      ws_valid_r  <= 1'b1;
      pc_r        <= ms_pc;
      excp_r      <= ms_excp;
      ertn_r      <= ms_ertn;
      csr_we_r    <= ms_csr_we;
      csr_num_r   <= ms_csr_num;
      csr_wdata_r <= ms_csr_wdata;
    end else begin
      ws_valid_r  <= 1'b0;
    end
  end

  // RUN/HOLD flush-gap FSM and exception counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RUN;
      gap_cnt_r    <= 4'd0;
      excp_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        RUN: begin
          if (excp_hit_s || ertn_hit_s) begin
            state_r   <= HOLD;
            gap_cnt_r <= GAP_INIT;
          end else begin
            state_r   <= RUN;
          end
        end
        HOLD: begin
          gap_cnt_r <= gap_cnt_r - 4'd1;
          if (gap_cnt_r <= 4'd1) begin
            state_r   <= RUN;
            gap_cnt_r <= 4'd0;
          end else begin
            state_r   <= HOLD;
          end
        end
        default: begin
          state_r   <= RUN;
          gap_cnt_r <= 4'd0;
        end
      endcase
      if (excp_hit_s) begin
        excp_count_r <= excp_count_r + 32'd1;
      end else begin
        excp_count_r <= excp_count_r;
      end
    end
  end

endmodule

// File: tb/tb_wb_excp_ctrl.sv
// Table-driven bench for wb_excp_ctrl with hand-computed vectors plus
// directed sequences for back-to-back commit, dropped instructions and reset during HOLD.
module tb_wb_excp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_excp;
  logic        ms_ertn;
  logic        ms_csr_we;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_csr_wdata;
  logic        has_int;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        csr_wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] era_in;
  logic [5:0]  ecode_in;
  logic [8:0]  esubcode_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_all;
  logic [31:0] excp_count;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_count;

  wb_excp_ctrl #(.FLUSH_GAP(2)) dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_excp(ms_excp), .ms_ertn(ms_ertn), .ms_csr_we(ms_csr_we),
    .ms_csr_num(ms_csr_num), .ms_csr_wdata(ms_csr_wdata), .has_int(has_int),
    .csr_eentry(csr_eentry), .csr_era(csr_era), .csr_wr_en(csr_wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .excp_flush(excp_flush), .ertn_flush(ertn_flush), .era_in(era_in),
    .ecode_in(ecode_in), .esubcode_in(esubcode_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_all(flush_all), .excp_count(excp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  excp;
    logic        ertn;
    logic        we;
    logic [13:0] num;
    logic [31:0] wdata;
    logic        intr;
    logic [31:0] eentry;
    logic [31:0] era;
    logic        e_wr_en;
    logic        e_xf;
    logic        e_ef;
    logic [5:0]  e_ecode;
    logic [31:0] e_rpc;
    logic        e_inc;
    logic [3:0]  e_hold;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ms_to_ws_valid = 1'b0; ms_pc = 32'h0; ms_excp = 5'b00000; ms_ertn = 1'b0;
    ms_csr_we = 1'b0; ms_csr_num = 14'h0; ms_csr_wdata = 32'h0; has_int = 1'b0;
    csr_eentry = 32'h0; csr_era = 32'h0;
  endtask

  // Count HOLD cycles (bounded) until ws_allowin returns; flush_all must stay high throughout.
  task automatic wait_hold(input string name, input logic [3:0] exp_len);
    int n = 0;
    while (!ws_allowin && n < 20) begin
      chk({name, "_hold_flush_all"}, 32'(flush_all), 32'd1);
      chk({name, "_hold_no_wr"}, 32'(csr_wr_en), 32'd0);
      tick();
      n++;
    end
    chk({name, "_hold_len"}, 32'(n), 32'(exp_len));
  endtask

  initial begin
    vecs[0] = '{32'h1C000100, 5'b00000, 1'b0, 1'b1, 14'h0030, 32'h000000A5, 1'b0, 32'h1C008000, 32'h00000000,
                1'b1, 1'b0, 1'b0, 6'h00, 32'h00000000, 1'b0, 4'd0};
    vecs[1] = '{32'h1C000200, 5'b00100, 1'b0, 1'b1, 14'h0030, 32'h00000055, 1'b0, 32'h1C008000, 32'h00000000,
                1'b0, 1'b1, 1'b0, 6'h0B, 32'h1C008000, 1'b1, 4'd2};
    vecs[2] = '{32'h1C000300, 5'b10001, 1'b1, 1'b0, 14'h0000, 32'h00000000, 1'b1, 32'h1C008000, 32'h1C000404,
                1'b0, 1'b1, 1'b0, 6'h00, 32'h1C008000, 1'b1, 4'd2};
    vecs[3] = '{32'h1C000400, 5'b00000, 1'b1, 1'b0, 14'h0000, 32'h00000000, 1'b0, 32'h1C008000, 32'h1C000404,
                1'b0, 1'b0, 1'b1, 6'h00, 32'h1C000404, 1'b0, 4'd2};
    vecs[4] = '{32'h1C000500, 5'b00011, 1'b0, 1'b0, 14'h0000, 32'h00000000, 1'b0, 32'h1C00C000, 32'h00000000,
                1'b0, 1'b1, 1'b0, 6'h08, 32'h1C00C000, 1'b1, 4'd2};
    vecs[5] = '{32'h1C000600, 5'b00110, 1'b0, 1'b0, 14'h0000, 32'h00000000, 1'b0, 32'h1C00C000, 32'h00000000,
                1'b0, 1'b1, 1'b0, 6'h09, 32'h1C00C000, 1'b1, 4'd2};
    vecs[6] = '{32'h1C000700, 5'b11000, 1'b0, 1'b0, 14'h0000, 32'h00000000, 1'b0, 32'h1C00C000, 32'h00000000,
                1'b0, 1'b1, 1'b0, 6'h0C, 32'h1C00C000, 1'b1, 4'd2};
    vecs[7] = '{32'h1C000800, 5'b10000, 1'b1, 1'b0, 14'h0000, 32'h00000000, 1'b0, 32'h1C00C000, 32'h1C000404,
                1'b0, 1'b1, 1'b0, 6'h0D, 32'h1C00C000, 1'b1, 4'd2};
    vecs[8] = '{32'h1C000900, 5'b00000, 1'b0, 1'b0, 14'h3FFF, 32'hFFFFFFFF, 1'b0, 32'h1C00C000, 32'h00000000,
                1'b0, 1'b0, 1'b0, 6'h00, 32'h00000000, 1'b0, 4'd0};
    vecs[9] = '{32'h1C000A00, 5'b00000, 1'b0, 1'b1, 14'h0001, 32'h00001234, 1'b1, 32'h1C010000, 32'h00000000,
                1'b0, 1'b1, 1'b0, 6'h00, 32'h1C010000, 1'b1, 4'd2};

    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_count = 32'h0;
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_flush_all", 32'(flush_all), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_wr_en", 32'(csr_wr_en), 32'd0);
    chk("rst_count", excp_count, 32'h0);

    // Interrupt with nothing committing must be ignored.
    has_int = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_int_flush", 32'(excp_flush), 32'd0);
      chk("idle_int_allowin", 32'(ws_allowin), 32'd1);
    end
    has_int = 1'b0;
    chk("idle_int_count", excp_count, exp_count);

    for (int v = 0; v < 10; v++) begin
      ms_to_ws_valid = 1'b1;
      ms_pc = vecs[v].pc; ms_excp = vecs[v].excp; ms_ertn = vecs[v].ertn;
      ms_csr_we = vecs[v].we; ms_csr_num = vecs[v].num; ms_csr_wdata = vecs[v].wdata;
      has_int = vecs[v].intr; csr_eentry = vecs[v].eentry; csr_era = vecs[v].era;
      tick();
      ms_to_ws_valid = 1'b0;
      chk($sformatf("v%0d_wr_en", v), 32'(csr_wr_en), 32'(vecs[v].e_wr_en));
      chk($sformatf("v%0d_excp_flush", v), 32'(excp_flush), 32'(vecs[v].e_xf));
      chk($sformatf("v%0d_ertn_flush", v), 32'(ertn_flush), 32'(vecs[v].e_ef));
      chk($sformatf("v%0d_redirect_valid", v), 32'(redirect_valid), 32'(vecs[v].e_xf | vecs[v].e_ef));
      chk($sformatf("v%0d_flush_all", v), 32'(flush_all), 32'(vecs[v].e_xf | vecs[v].e_ef));
      chk($sformatf("v%0d_esubcode", v), 32'(esubcode_in), 32'd0);
      if (vecs[v].e_xf) begin
        chk($sformatf("v%0d_ecode", v), 32'(ecode_in), 32'(vecs[v].e_ecode));
        chk($sformatf("v%0d_era_in", v), era_in, vecs[v].pc);
      end
      if (vecs[v].e_xf | vecs[v].e_ef) begin
        chk($sformatf("v%0d_redirect_pc", v), redirect_pc, vecs[v].e_rpc);
      end else begin
        chk($sformatf("v%0d_wr_addr", v), 32'(wr_addr), 32'(vecs[v].num));
        chk($sformatf("v%0d_wr_data", v), wr_data, vecs[v].wdata);
      end
      tick();
      has_int = 1'b0;
      if (vecs[v].e_inc) exp_count = exp_count + 32'd1;
      chk($sformatf("v%0d_count", v), excp_count, exp_count);
      wait_hold($sformatf("v%0d", v), vecs[v].e_hold);
    end

    // Back-to-back transfers commit one per cycle.
    clear_inputs();
    ms_to_ws_valid = 1'b1; ms_csr_we = 1'b1; ms_csr_num = 14'h0010; ms_csr_wdata = 32'h00000111;
    tick();
    ms_csr_num = 14'h0011; ms_csr_wdata = 32'h00000222;
    chk("b2b_0_wr_en", 32'(csr_wr_en), 32'd1);
    chk("b2b_0_addr", 32'(wr_addr), 32'h10);
    chk("b2b_0_data", wr_data, 32'h111);
    chk("b2b_0_allowin", 32'(ws_allowin), 32'd1);
    tick();
    ms_to_ws_valid = 1'b0;
    chk("b2b_1_wr_en", 32'(csr_wr_en), 32'd1);
    chk("b2b_1_addr", 32'(wr_addr), 32'h11);
    chk("b2b_1_data", wr_data, 32'h222);
    tick();
    chk("b2b_idle_wr_en", 32'(csr_wr_en), 32'd0);

    // Instruction accepted during an exception commit is discarded by the flush.
    clear_inputs();
    ms_to_ws_valid = 1'b1; ms_excp = 5'b01000; ms_pc = 32'h1C000B00; csr_eentry = 32'h1C008000;
    tick();
    ms_excp = 5'b00000; ms_csr_we = 1'b1; ms_csr_num = 14'h0022; ms_csr_wdata = 32'h00000033;
    chk("drop_excp_flush", 32'(excp_flush), 32'd1);
    chk("drop_ecode", 32'(ecode_in), 32'h0C);
    tick();
    ms_to_ws_valid = 1'b0;
    exp_count = exp_count + 32'd1;
    chk("drop_count", excp_count, exp_count);
    wait_hold("drop", 4'd2);
    chk("drop_after_wr_en", 32'(csr_wr_en), 32'd0);
    chk("drop_after_redirect", 32'(redirect_valid), 32'd0);

    // Reset arriving while the pipe is in HOLD.
    clear_inputs();
    ms_to_ws_valid = 1'b1; ms_excp = 5'b00100; ms_pc = 32'h1C000C00; csr_eentry = 32'h1C008000;
    tick();
    ms_to_ws_valid = 1'b0;
    chk("rsthold_excp_flush", 32'(excp_flush), 32'd1);
    tick();
    chk("rsthold_in_hold", 32'(ws_allowin), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 32'h0;
    chk("rsthold_allowin", 32'(ws_allowin), 32'd1);
    chk("rsthold_flush_all", 32'(flush_all), 32'd0);
    chk("rsthold_count", excp_count, exp_count);
    chk("rsthold_redirect", 32'(redirect_valid), 32'd0);
    tick();
    chk("rsthold_stay_run", 32'(ws_allowin), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_excp_ctrl.md
WB_EXCP_CTRL -- requirements
Module: wb_excp_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_GAP, default 2, meaning post-flush hold cycles (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ms_to_ws_valid  input  1  upstream (mem stage) instruction valid.
REQ-005 SHALL have port ws_allowin  output  1  this stage accepts an instruction this cycle.
REQ-006 SHALL have port ms_pc  input  32  instruction PC.
REQ-007 SHALL have port ms_excp  input  5  flags {ine,brk,sys,ale,adef} (bit0=adef).
REQ-008 SHALL have port ms_ertn  input  1  instruction is ERTN.
REQ-009 SHALL have ports ms_csr_we (1), ms_csr_num (14), ms_csr_wdata (32), all inputs: CSR write request.
REQ-010 SHALL have ports has_int (1), csr_eentry (32), csr_era (32), all inputs from the CSR file.
REQ-011 SHALL have ports csr_wr_en (1), wr_addr (14), wr_data (32), all outputs to the CSR file.
REQ-012 SHALL have ports excp_flush (1), ertn_flush (1), era_in (32), ecode_in (6), esubcode_in (9), all outputs to the CSR file.
REQ-013 SHALL have ports redirect_valid (1), redirect_pc (32), flush_all (1), excp_count (32), all outputs.

Function
REQ-014 SHALL hold one pipeline register: ws_valid plus latched pc, excp, ertn, csr_we/num/wdata.
REQ-015 SHALL assert ws_allowin = (state==RUN); a transfer occurs when ms_to_ws_valid && ws_allowin, loading the register on that edge.
REQ-016 SHALL clear ws_valid on any edge without a transfer; each latched instruction commits in exactly one cycle (latency 1 from transfer to commit outputs).
REQ-017 SHALL define commit cycle = ws_valid && state==RUN; all commit outputs are combinational from the register and are 0 outside a commit cycle.
REQ-018 SHALL classify at commit with priority INT > ADEF > ALE > SYS > BRK > INE; INT means has_int==1 in the commit cycle.
REQ-019 SHALL encode ecode_in: INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D; esubcode_in = 0 for all.
REQ-020 SHALL on exception commit pulse excp_flush=1, era_in=pc, redirect_valid=1, redirect_pc=csr_eentry, flush_all=1, csr_wr_en=0.
REQ-021 SHALL on ERTN commit without exception pulse ertn_flush=1, redirect_valid=1, redirect_pc=csr_era, flush_all=1.
REQ-022 SHALL on normal commit drive csr_wr_en=csr_we, wr_addr=csr_num, wr_data=csr_wdata; no flush, no redirect.
REQ-023 SHALL never assert excp_flush and ertn_flush together; exception/interrupt wins over ERTN.
REQ-024 SHALL implement FSM RUN/HOLD: RUN -> HOLD on exception or ERTN commit, loading 4-bit gap counter with FLUSH_GAP.
REQ-025 SHALL in HOLD decrement the counter each cycle, assert flush_all=1, ws_allowin=0; HOLD -> RUN on the edge where counter==1.
REQ-026 SHALL increment excp_count by 1 on each exception commit (INT included, ERTN excluded), wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL ignore has_int when ws_valid==0 (interrupts taken only on a committing instruction).

Reset
REQ-028 SHALL on reset: state=RUN, ws_valid=0, gap counter=0, excp_count=0; all outputs 0 except ws_allowin=1, including when reset arrives mid-HOLD or mid-commit.

Verification
REQ-029 SHALL verify: valid pc=0x1C000100, csr_we=1, num=0x30, wdata=0xA5 -> next cycle csr_wr_en=1, wr_addr=0x30, wr_data=0xA5, no flush.
REQ-030 SHALL verify: instruction with ms_excp=5'b00100 (sys), pc=0x1C000200, eentry=0x1C008000 -> excp_flush=1, ecode_in=0x0B, era_in=0x1C000200, redirect_pc=0x1C008000, csr_wr_en=0, then ws_allowin=0 for exactly 2 cycles.
REQ-031 SHALL verify: has_int=1 with ms_excp=5'b10001 and ertn=1 -> ecode_in=0x00, ertn_flush=0, excp_count increments by 1.
REQ-032 SHALL verify: ERTN with csr_era=0x1C000404 -> ertn_flush=1, redirect_pc=0x1C000404, excp_count unchanged.
REQ-033 SHALL verify: reset asserted during HOLD -> next cycle ws_allowin=1, flush_all=0, excp_count=0; back-to-back valid instructions in RUN commit one per cycle.
